usb_txf: RTL

USB_TXF -- requirements
Module: usb_txf

---
 rtl/usb_txf_if.sv | 22 ++
 rtl/usb_txf.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/usb_txf_if.sv
// Link-side bundle for the nibble framer: frame request, FIFO fetch and nibble output.
// The framer itself uses the slave modport; the driving/observing side uses master.
interface usb_txf_if;
  logic       start;
  logic [7:0] len;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [3:0] dout;
  logic       fire;
  logic       busy;
  logic       done;

  modport master (
    output start, len, rd_data,
    input  rd_en, dout, fire, busy, done
  );

  modport slave (
    input  start, len, rd_data,
    output rd_en, dout, fire, busy, done
  );
endinterface

// File: rtl/usb_txf.sv
// Nibble framer: preamble, 0xF sync, then payload bytes as HI/LO nibbles, idle gap, done pulse.
// Define USB_TXF_CHK_EN to append an XOR check byte after the payload.
module usb_txf #(
  parameter int PRE_LEN = 2,
  parameter int GAP_LEN = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  usb_txf_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SYNC = 3'd2,
    HI   = 3'd3,
    LO   = 3'd4,
    GAP  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [3:0] PRE_L = PRE_LEN[3:0];
  localparam logic [3:0] GAP_L = GAP_LEN[3:0];

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] len_r;
  logic [7:0] byte_cnt;
  logic [3:0] byte_lo;
`ifdef USB_TXF_CHK_EN
  logic [7:0] chk_r;
`endif

  logic [7:0] last_idx;
  logic       is_final;
  logic       next_is_payload;
  logic       next_rd;

  // The check byte, when enabled, sits one index past the last payload byte.
  always_comb begin
`ifdef USB_TXF_CHK_EN
    last_idx = len_r;
`else
    last_idx = len_r - 8'd1;
`endif
    is_final        = (byte_cnt == last_idx);
    next_is_payload = ({1'b0, byte_cnt} + 9'd1) < {1'b0, len_r};
    next_rd         = ({1'b0, byte_cnt} + 9'd2) < {1'b0, len_r};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      len_r       <= 8'd0;
      byte_cnt    <= 8'd0;
      byte_lo     <= 4'd0;
`ifdef USB_TXF_CHK_EN
      chk_r       <= 8'd0;
`endif
      bus.dout    <= 4'h0;
      bus.fire    <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.dout  <= 4'h0;
          bus.fire  <= 1'b0;
          bus.rd_en <= 1'b0;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b0;
          if (bus.start && (bus.len != 8'd0)) begin
            state     <= PRE;
            len_r     <= bus.len;
            byte_cnt  <= 8'd0;
            cnt       <= 4'd1;
`ifdef USB_TXF_CHK_EN
            chk_r     <= 8'd0;
`endif
            bus.fire  <= 1'b1;
            bus.busy  <= 1'b1;
            bus.rd_en <= (PRE_L == 4'd1);
          end
        end
        // First byte is fetched during the last preamble cycle so it lands in SYNC.
        PRE: begin
          if (cnt == PRE_L) begin
            state     <= SYNC;
            bus.dout  <= 4'hF;
            bus.rd_en <= 1'b0;
          end else begin
            cnt       <= cnt + 4'd1;
            bus.rd_en <= ((cnt + 4'd1) == PRE_L);
          end
        end
        SYNC: begin
          state     <= HI;
          byte_lo   <= bus.rd_data[3:0];
          bus.dout  <= bus.rd_data[7:4];
          bus.rd_en <= next_is_payload;
`ifdef USB_TXF_CHK_EN
          chk_r     <= chk_r ^ bus.rd_data;
`endif
        end
        HI: begin
          state     <= LO;
          bus.dout  <= byte_lo;
          bus.rd_en <= 1'b0;
          bus.fire  <= !is_final;
        end
        LO: begin
          if (is_final) begin
            state    <= GAP;
            bus.dout <= 4'h0;
            bus.fire <= 1'b0;
            cnt      <= 4'd1;
          end else begin
            state     <= HI;
            byte_cnt  <= byte_cnt + 8'd1;
            bus.fire  <= 1'b1;
            bus.rd_en <= next_rd;
`ifdef USB_TXF_CHK_EN
            if (next_is_payload) begin
              byte_lo  <= bus.rd_data[3:0];
              bus.dout <= bus.rd_data[7:4];
              chk_r    <= chk_r ^ bus.rd_data;
            end else begin
              byte_lo  <= chk_r[3:0];
              bus.dout <= chk_r[7:4];
            end
`else
            byte_lo  <= bus.rd_data[3:0];
            bus.dout <= bus.rd_data[7:4];
`endif
          end
        end
        GAP: begin
          if (cnt == GAP_L) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus.dout  <= 4'h0;
          bus.fire  <= 1'b0;
          bus.rd_en <= 1'b0;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
